tmds_video_sequencer: RTL



---
 rtl/tmds_pkg.sv | 27 ++
 rtl/video_raster_counter.sv | 72 +++++++
 rtl/tmds_video_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS video output path: control codes, 640x480@60 timing
// defaults and the sequencer state type.
package tmds_pkg;

    // 10-bit TMDS control symbols, indexed by {C1, C0}
    localparam logic [9:0] TmdsCtrl00 = 10'b1101010100;
    localparam logic [9:0] TmdsCtrl01 = 10'b0010101011;
    localparam logic [9:0] TmdsCtrl10 = 10'b0101010100;
    localparam logic [9:0] TmdsCtrl11 = 10'b1010101011;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;
    localparam int unsigned DefCw      = 12;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } seq_state_e;

endpackage

// File: rtl/video_raster_counter.sv
// Horizontal/vertical raster position with region decode. Sync flags are logical
// (1 = asserted); polarity is applied by the caller.
module video_raster_counter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance_i,
    output logic [CW-1:0] hcnt_o,
    output logic [CW-1:0] vcnt_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          last_o
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HLast     = CW'(HTotal - 1);
    localparam logic [CW-1:0] VLast     = CW'(VTotal - 1);
    localparam logic [CW-1:0] HActEnd   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VActEnd   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HSyncBeg  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HSyncEnd  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VSyncBeg  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VSyncEnd  = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (advance_i) begin
            if (hcnt_q == HLast) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hcnt_o   = hcnt_q;
        vcnt_o   = vcnt_q;
        active_o = (hcnt_q < HActEnd) && (vcnt_q < VActEnd);
        hsync_o  = (hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd);
        vsync_o  = (vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd);
        last_o   = (hcnt_q == HLast) && (vcnt_q == VLast);
    end

endmodule

// File: rtl/tmds_video_sequencer.sv
// Video timing sequencer feeding the red/green/blue TMDS encoders. Pulls pixels over
// valid/ready and starts/stops only on frame boundaries.
module tmds_video_sequencer
    import tmds_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DefHActive,
    parameter int unsigned H_FP      = DefHFp,
    parameter int unsigned H_SYNC    = DefHSync,
    parameter int unsigned H_BP      = DefHBp,
    parameter int unsigned V_ACTIVE  = DefVActive,
    parameter int unsigned V_FP      = DefVFp,
    parameter int unsigned V_SYNC    = DefVSync,
    parameter int unsigned V_BP      = DefVBp,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = DefCw
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic [7:0]  red_vd,
    output logic [7:0]  green_vd,
    output logic [7:0]  blue_vd,
    output logic [1:0]  red_cd,
    output logic [1:0]  green_cd,
    output logic [1:0]  blue_cd,
    output logic        vde,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        busy
);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] hcnt, vcnt;
    logic          active, hsync, vsync, last_pos, running;

    logic [23:0] vd_q, vd_d;
    logic        vde_q, vde_d;
    logic [1:0]  blue_cd_q, blue_cd_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;

    video_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .advance_i (running),
        .hcnt_o    (hcnt),
        .vcnt_o    (vcnt),
        .active_o  (active),
        .hsync_o   (hsync),
        .vsync_o   (vsync),
        .last_o    (last_pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A drop of enable in RUN always drains to the end of the frame in progress.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = StDrain;
            StDrain: if (last_pos) state_d = enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        running       = (state_q != StIdle);
        pix_ready     = running && active;
        busy          = running;
        vde_d         = running && active;
        vd_d          = (vde_d && pix_valid) ? pix_data : '0;
        blue_cd_d     = {(running && vsync) ? VSYNC_POL : ~VSYNC_POL,
                         (running && hsync) ? HSYNC_POL : ~HSYNC_POL};
        frame_start_d = running && (hcnt == '0) && (vcnt == '0);
        // A new underflow outranks a same-cycle clear.
        underflow_d   = (underflow_q && !underflow_clr) || (vde_d && !pix_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vd_q          <= '0;
            vde_q         <= 1'b0;
            blue_cd_q     <= {~VSYNC_POL, ~HSYNC_POL};
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            vd_q          <= vd_d;
            vde_q         <= vde_d;
            blue_cd_q     <= blue_cd_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign red_vd      = vd_q[23:16];
    assign green_vd    = vd_q[15:8];
    assign blue_vd     = vd_q[7:0];
    assign red_cd      = 2'b00;
    assign green_cd    = 2'b00;
    assign blue_cd     = blue_cd_q;
    assign vde         = vde_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
